// File: rtl/sdf_fft32_pkg.sv
// Shared constants, state type and helpers for the 32-point SDF FFT sequencer.
package sdf_fft32_pkg;

  localparam int NPT     = 32;
  localparam int NSTG    = 5;
  localparam int STG_REG = 1;
  localparam int CNT_W   = $clog2(NPT);

  // Cycle offset of stage s: sum of the latencies of all stages ahead of it.
  function automatic int stage_off(input int s);
    int acc;
    acc = 0;
    for (int i = 0; i < s; i++) begin
      acc += (16 >> i) + STG_REG;
    end
    return acc;
  endfunction

  localparam int STG_OFF [NSTG] = '{stage_off(0), stage_off(1), stage_off(2),
                                    stage_off(3), stage_off(4)};

  // Total pipe latency: a sample entering stage 0 leaves the last stage L advances later.
  localparam int L      = stage_off(NSTG - 1) + 1 + STG_REG;
  localparam int FCNT_W = $clog2(L + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) begin
      r[i] = v[4-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_fft32_ctrl_if.sv
// Handshake and control bundle between the sequencer and the SDF pipeline.
interface sdf_fft32_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        flush_req;
  logic        stage_en;
  logic        in_zero;
  logic [4:0]  bf_en;
  logic [29:0] tw_addr;
  logic        out_valid;
  logic [4:0]  out_index;
  logic        frame_done;
  logic        busy;

  modport master (
    input  in_valid, flush_req,
    output in_ready, stage_en, in_zero, bf_en, tw_addr,
           out_valid, out_index, frame_done, busy
  );

  modport slave (
    output in_valid, flush_req,
    input  in_ready, stage_en, in_zero, bf_en, tw_addr,
           out_valid, out_index, frame_done, busy
  );
endinterface

// File: rtl/sdf_stage_seq.sv
// Per-stage decode: local count, butterfly/bypass select and twiddle address.
module sdf_stage_seq
  import sdf_fft32_pkg::*;
#(
  parameter int STAGE  = 0,
  parameter int OFF    = 0,
  parameter int TW_OFS = 0
) (
  input  logic [4:0] acnt_i,
  input  logic       active_i,
  output logic       bf_en_o,
  output logic [5:0] tw_addr_o
);

  localparam logic [4:0] OFF5 = 5'(OFF % 32);
  localparam logic [5:0] TWO6 = 6'(TW_OFS % 64);

  logic [4:0] k;

  // Local count wraps mod 32; the stage's half-period bit selects butterfly mode.
  assign k         = acnt_i - OFF5;
  assign bf_en_o   = active_i & k[NSTG-1-STAGE];
  assign tw_addr_o = active_i ? ({1'b0, k} + TWO6) : 6'd0;

endmodule

// File: rtl/sdf_fft32_ctrl.sv
// Sequencing controller for the 32-point radix-2 SDF FFT pipeline.
module sdf_fft32_ctrl
  import sdf_fft32_pkg::*;
#(
  parameter int TW_OFS = 0
) (
  input  logic             clk,
  input  logic             rst,
  sdf_fft32_ctrl_if.master bus
);

  localparam logic [FCNT_W-1:0] L_W = FCNT_W'(L);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   acnt_q, acnt_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;
  logic [CNT_W-1:0]   ocnt_q, ocnt_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [FCNT_W-1:0]  fl_rem_q, fl_rem_d;
  logic               pend_q, pend_d;

  logic               st_idle, st_run, st_flush;
  logic               stage_en, out_valid;
  logic [FCNT_W-1:0]  fcnt_inc;
  logic [4:0]         bf_en;
  logic [29:0]        tw_addr;

  assign st_idle  = (state_q == ST_IDLE);
  assign st_run   = (state_q == ST_RUN);
  assign st_flush = (state_q == ST_FLUSH);

  // During flush the pipe is advanced every cycle with zeros, whatever the source does.
  assign stage_en  = ((st_idle | st_run) & bus.in_valid) | st_flush;
  assign out_valid = (st_run & stage_en & (fcnt_q == L_W)) |
                     (st_flush & (fl_rem_q <= fcnt_q));
  assign fcnt_inc  = (fcnt_q == L_W) ? fcnt_q : fcnt_q + 1'b1;

  assign bus.stage_en   = stage_en;
  assign bus.in_ready   = ~st_flush;
  assign bus.in_zero    = st_flush;
  assign bus.busy       = ~st_idle;
  assign bus.out_valid  = out_valid;
  assign bus.out_index  = bitrev5(ocnt_q);
  assign bus.frame_done = out_valid & (ocnt_q == '1);
  assign bus.bf_en      = bf_en;
  assign bus.tw_addr    = tw_addr;

  for (genvar g = 0; g < NSTG; g++) begin : g_stage
    sdf_stage_seq #(
      .STAGE  (g),
      .OFF    (STG_OFF[g]),
      .TW_OFS (TW_OFS)
    ) u_seq (
      .acnt_i    (acnt_q),
      .active_i  (~st_idle),
      .bf_en_o   (bf_en[g]),
      .tw_addr_o (tw_addr[6*g +: 6])
    );
  end

  // Next-state and counter update for IDLE / RUN / FLUSH.
  always_comb begin
    // NOTE: every _d takes its _q first so no path through this block can infer a latch.
    state_d  = state_q;
    acnt_d   = acnt_q;
    scnt_d   = scnt_q;
    ocnt_d   = ocnt_q;
    fcnt_d   = fcnt_q;
    fl_rem_d = fl_rem_q;
    pend_d   = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_RUN;
          acnt_d  = acnt_q + 1'b1;
          scnt_d  = scnt_q + 1'b1;
          fcnt_d  = fcnt_inc;
        end
      end
      ST_RUN: begin
        if (stage_en) begin
          acnt_d = acnt_q + 1'b1;
          scnt_d = scnt_q + 1'b1;
          fcnt_d = fcnt_inc;
        end
        if (out_valid) ocnt_d = ocnt_q + 1'b1;
        pend_d = pend_q | bus.flush_req;
        // Drain only at a frame boundary, judged after this cycle's acceptance.
        if (pend_d && (scnt_d == '0)) begin
          state_d  = ST_FLUSH;
          fl_rem_d = L_W;
          pend_d   = 1'b0;
        end
      end
      ST_FLUSH: begin
        acnt_d   = acnt_q + 1'b1;
        fl_rem_d = fl_rem_q - 1'b1;
        if (out_valid) ocnt_d = ocnt_q + 1'b1;
        if (fl_rem_q == FCNT_W'(1)) begin
          state_d  = ST_IDLE;
          acnt_d   = '0;
          scnt_d   = '0;
          ocnt_d   = '0;
          fcnt_d   = '0;
          fl_rem_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it sits inside the clocked branch and not in the sensitivity list.
    if (rst) begin
      state_q  <= ST_IDLE;
      acnt_q   <= '0;
      scnt_q   <= '0;
      ocnt_q   <= '0;
      fcnt_q   <= '0;
      fl_rem_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acnt_q   <= acnt_d;
      scnt_q   <= scnt_d;
      ocnt_q   <= ocnt_d;
      fcnt_q   <= fcnt_d;
      fl_rem_q <= fl_rem_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_sdf_fft32_ctrl.sv
// Self-checking bench for sdf_fft32_ctrl against a sample-count reference model.
module tb_sdf_fft32_ctrl;

  localparam int TW_OFS = 40;
  localparam int LAT    = 36;
  localparam int OFFS [5] = '{0, 17, 26, 31, 34};

  logic clk;
  logic rst;

  sdf_fft32_ctrl_if bus ();

  sdf_fft32_ctrl #(.TW_OFS(TW_OFS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 run, 2 flush; totals since last return to idle.
  int m_mode, m_acc, m_adv, m_pend, m_j, m_fill, m_outs;
  // Observed statistics for scenario-level checks.
  int s_ov, s_fd, s_zero, s_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rev5(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++) r |= ((v >> i) & 1) << (4 - i);
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_acc = 0; m_adv = 0; m_pend = 0;
    m_j = 0; m_fill = 0; m_outs = 0;
  endtask

  task automatic stats_reset();
    s_ov = 0; s_fd = 0; s_zero = 0; s_acc = 0;
  endtask

  task automatic compare(input bit iv);
    logic [4:0]  e_bf;
    logic [29:0] e_tw;
    bit          e_en, e_ov, e_fd;
    int          k, e_idx;
    e_bf = '0;
    e_tw = '0;
    e_en = (m_mode == 2) || iv;
    if (m_mode != 0) begin
      for (int s = 0; s < 5; s++) begin
        k = (m_adv - OFFS[s] + 64) % 32;
        e_bf[s] = 1'((k >> (4 - s)) & 1);
        e_tw[6*s +: 6] = 6'((k + TW_OFS) % 64);
      end
    end
    if (m_mode == 1)      e_ov = iv && (m_acc >= LAT);
    else if (m_mode == 2) e_ov = ((LAT + 1 - m_j) <= m_fill);
    else                  e_ov = 1'b0;
    e_idx = rev5(m_outs % 32);
    e_fd  = e_ov && ((m_outs % 32) == 31);

    check("ctl", 32'({bus.in_ready, bus.stage_en, bus.in_zero, bus.busy}),
          32'({m_mode != 2, e_en, m_mode == 2, m_mode != 0}));
    check("bf_en",   32'(bus.bf_en), 32'(e_bf));
    check("tw_addr", 32'(bus.tw_addr), 32'(e_tw));
    check("out", 32'({bus.out_valid, bus.frame_done, bus.out_index}),
          32'({e_ov, e_fd, 5'(e_idx)}));
  endtask

  task automatic model_step(input bit iv, input bit fr, input bit r);
    if (r) begin
      model_reset();
    end else begin
      case (m_mode)
        0: if (iv) begin
             m_mode = 1; m_acc = 1; m_adv = 1;
           end
        1: begin
             if (iv) begin
               if (m_acc >= LAT) m_outs++;
               m_acc++;
               m_adv++;
             end
             if (fr) m_pend = 1;
             if (m_pend != 0 && (m_acc % 32) == 0) begin
               m_mode = 2; m_j = 1; m_pend = 0;
               m_fill = (m_acc < LAT) ? m_acc : LAT;
             end
           end
        default: begin
             if ((LAT + 1 - m_j) <= m_fill) m_outs++;
             m_adv++;
             if (m_j == LAT) model_reset();
             else m_j++;
           end
      endcase
    end
  endtask

  task automatic step(input bit iv, input bit fr, input bit r);
    bus.in_valid  = iv;
    bus.flush_req = fr;
    rst           = r;
    #3;
    compare(iv);
    if (bus.out_valid)  s_ov++;
    if (bus.frame_done) s_fd++;
    if (bus.in_zero)    s_zero++;
    if (bus.stage_en && !bus.in_zero && s_zero == 0) s_acc++;
    @(posedge clk);
    #1;
    model_step(iv, fr, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.flush_req = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Continuous stream: stage fill, first output, bit-reversed indices, frame_done.
    step(0, 0, 0);
    for (int i = 0; i < 70; i++) step(1, 0, 0);

    // Stall of three cycles at acnt 10.
    step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++)  step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);

    // 64 samples, flush at the boundary.
    step(0, 0, 1);
    stats_reset();
    for (int i = 0; i < 64; i++) step(1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 38; i++) step(0, 0, 0);
    check("flush64_outs",  32'(s_ov), 32'd64);
    check("flush64_fdone", 32'(s_fd), 32'd2);
    check("flush64_len",   32'(s_zero), 32'd36);
    check("flush64_busy",  32'(bus.busy), 32'd0);

    // Mid-frame flush request at scnt 5: drain waits for the full frame.
    step(0, 0, 1);
    stats_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < 80; i++) step(1'(i % 5 != 2), 0, 0);
    check("midflush_acc", 32'(s_acc), 32'd32);

    // Exactly one frame; flush_req coincides with the 32nd sample.
    step(0, 0, 1);
    stats_reset();
    for (int i = 0; i < 31; i++) step(1, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < 38; i++) step(0, 0, 0);
    check("flush32_outs",  32'(s_ov), 32'd32);
    check("flush32_fdone", 32'(s_fd), 32'd1);
    check("flush32_len",   32'(s_zero), 32'd36);

    // Reset in the middle of a frame, then restart.
    step(0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // Randomised traffic with occasional flush requests and resets.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdf_fft32_ctrl.md
Name: sdf_fft32_ctrl

Overview:
- Sequencing controller for the 32-point radix-2 single-path-delay-feedback (SDF) FFT pipeline.
- Drives the global stage advance enable, the per-stage butterfly/bypass select and the per-stage twiddle-ROM addresses (the 6-bit address into the stage ROMs).
- Handles input stalls, end-of-stream flush with zero insertion, output valid, and bit-reversed output index tagging.
- Sits between the sample source and the five SDF stages. It owns no datapath arithmetic.

Parameters:
- NPT, 32: FFT points; fixed at 32, with log2 = 5 stages.
- STG_REG, 1: pipeline registers per stage after its delay line. Stage s latency = (16>>s) + STG_REG.
- TW_OFS, 0: constant added, modulo 64, to every twiddle ROM address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input sample present this cycle
- in_ready  out  1  controller accepts input; low only in FLUSH
- flush_req  in  1  request drain at the next frame boundary (single-cycle pulse)
- stage_en  out  1  advance enable for all stage registers and delay lines
- in_zero  out  1  force stage-0 input to zero (flush)
- bf_en  out  5  bit s = 1: stage s butterfly mode; 0: fill/bypass mode
- tw_addr  out  30  6 bits per stage; stage s uses bits [6s+5:6s]
- out_valid  out  1  last-stage output is a valid FFT bin this cycle
- out_index  out  5  bin index of the current output (bit-reversed order counter)
- frame_done  out  1  pulse with the output of the 32nd bin of a frame
- busy  out  1  state != IDLE

Behaviour:
- Constants. off_s = sum over i<s of ((16>>i)+STG_REG), giving 0, 17, 26, 31, 34. L = off_4 + 1 + STG_REG = 36.
- State and counters:
  - FSM states: IDLE, RUN, FLUSH.
  - acnt: 5-bit advance count, wraps.
  - scnt: 5-bit accepted-sample count.
  - fcnt: 0..L, valid samples in the pipe, saturating.
  - fl_rem: 0..L.
  - ocnt: 5-bit.
  - flush_pend flag.
- Reset:
  - State IDLE; all counters and flags are 0.
  - Every output is 0, except in_ready = 1 and bf_en = 0.
  - Reset takes effect at the next clk edge regardless of state; any in-flight frame is discarded.
- stage_en = (RUN & in_valid) | FLUSH, or (IDLE & in_valid). All outputs are combinational from the registered state; there is no extra latency.
- IDLE:
  - in_valid = 1 moves the FSM to RUN. That sample is accepted (stage_en = 1) with acnt = 0.
  - acnt, scnt and fcnt are 0 on entry to IDLE.
- RUN:
  - Each cycle with stage_en = 1: acnt++, scnt++, fcnt++ (saturating at L).
  - in_valid = 0 is a stall: stage_en = 0, all counters hold, and bf_en/tw_addr hold their values.
- Per-stage local count: k_s = (acnt - off_s) mod 32.
  - bf_en[s] = k_s[4-s].
  - tw_addr field s = ({1'b0,k_s} + TW_OFS) mod 64.
- Output valid and index:
  - RUN: out_valid = stage_en & (fcnt == L).
  - out_index = bit-reverse(ocnt). ocnt increments on each out_valid.
  - frame_done = out_valid & (ocnt == 31).
- Flush request:
  - flush_req sets flush_pend.
  - The FSM moves to FLUSH when flush_pend = 1, the FSM is in RUN and scnt == 0. Sampling of this condition occurs after that cycle's acceptance, i.e. at a frame boundary.
  - A mid-frame flush_req stays pending until 32 samples have completed.
  - flush_req in IDLE is ignored.
- FLUSH:
  - Entered with fl_rem = L; flush_pend is cleared.
  - Each cycle: stage_en = 1, in_zero = 1, in_ready = 0, acnt++, fl_rem--.
  - in_valid is ignored.
  - out_valid = (fl_rem <= fcnt), with fl_rem taken as the pre-decrement value.
  - After the cycle with fl_rem == 1, the FSM goes to IDLE and clears fcnt, acnt, scnt and ocnt.
- Simultaneous events:
  - rst dominates everything.
  - flush_req in the same cycle as a boundary completes (scnt wraps to 0 that cycle) enters FLUSH on the next cycle.

Decomposition:
- Shared package sdf_fft32_pkg holds:
  - NPT, NSTG = 5, STG_REG;
  - the derived off_s array and L;
  - the FSM state typedef;
  - the bitrev5 function.
- One sub-module, sdf_stage_seq. Instantiated five times, it computes k_s, bf_en[s] and tw_addr field s from acnt, with off_s as a parameter.

Test Plan:
- Reset, then in_valid held high for 64 cycles:
  - bf_en[0] = 0 for acnt 0-15 and 1 for acnt 16-31.
  - bf_en[1] goes high when k_1 = 8, i.e. acnt = 25.
  - First out_valid occurs on the 37th accepted cycle.
  - out_index runs 0, 16, 8, 24, 4, ...
  - frame_done fires on the 32nd valid output.
- in_valid dropped for 3 cycles at acnt = 10:
  - stage_en = 0 for those 3 cycles.
  - acnt, bf_en, tw_addr and out_valid hold.
  - Processing resumes with acnt = 10.
- 64 samples, then flush_req at the boundary:
  - FLUSH lasts 36 cycles with in_zero = 1 and in_ready = 0.
  - out_valid is high on all 36 cycles, giving 64 outputs total and 2 frame_done pulses.
  - busy falls after the last cycle.
- flush_req pulsed at scnt = 5:
  - RUN continues until 32 samples are accepted, then FLUSH begins.
  - No sample is dropped.
- 32 samples, then flush:
  - out_valid is low for FLUSH cycles 1-4 and high for cycles 5-36 (32 outputs).
  - Exactly one frame_done pulse.
- rst asserted at acnt = 20 in RUN:
  - The next cycle shows all outputs at reset values and state IDLE.
  - A new in_valid restarts from acnt = 0.
